dout_nibble_serializer: RTL and testbench
=========================================

# dout_nibble_serializer

Output-observation stage placed directly downstream of the HLS kernel inside the board-level wrapper. It consumes the kernel's two ap_fifo output streams (D_out_0, D_out_1), folds every accepted word into a per-run signature and word count, and on each kernel ap_done emits a 13-nibble frame on the 4-bit data_out/data_valid pins. This keeps all kernel outputs live through implementation so power measurements reflect real datapath activity. probe_out is a per-frame heartbeat.

## Interface
- DATA_W, 32, stream word width; multiple of 4; fixed at 32 for the frame format below
- CNT_W, 16, word-count width; multiple of 4
- ap_clk  in  1  kernel clock; all logic on rising edge
- ap_rst  in  1  asynchronous, active-high reset
- D_out_0_din  in  DATA_W  stream 0 data
- D_out_0_write  in  1  stream 0 write strobe
- D_out_0_full_n  out  1  stream 0 ready
- D_out_1_din  in  DATA_W  stream 1 data
- D_out_1_write  in  1  stream 1 write strobe
- D_out_1_full_n  out  1  stream 1 ready
- ap_done  in  1  kernel run-complete pulse (one cycle)
- data_out  out  4  frame nibble
- data_valid  out  1  data_out qualifier
- probe_out  out  1  toggles at end of every frame
- overrun  out  1  sticky: a run's snapshot was dropped

## Operation
- Accept: word on stream k accepted when D_out_k_write & D_out_k_full_n. Writes with full_n=0 ignored.
- Signature: sig_next = sig ^ (acc0 ? din0 : 0) ^ (acc1 ? rotl(din1,1) : 0). Both streams may accept in the same cycle.
- Count: cnt_next = cnt + acc0 + acc1, saturating at all-ones.
- ap_done cycle: snapshot {sig_next, cnt_next} (includes that cycle's writes); sig and cnt cleared to 0 at the same edge.
- Snapshot buffer: one entry (snap, snap_valid). ap_done while snap_valid=1 → new snapshot dropped, older kept, overrun set (cleared only by reset).
- FSM IDLE/SHIFT:
  - IDLE: snap_valid=1 → load shifter with frame, clear snap_valid, go SHIFT.
  - SHIFT: present one nibble per cycle, data_valid=1; after nibble 13 go IDLE, toggle probe_out.
- Frame order: 4'hA header, sig[31:28]..sig[3:0] (8 nibbles), cnt[15:12]..cnt[3:0] (4 nibbles).
- Signature accumulation continues undisturbed during SHIFT; the shifter works only on its loaded copy.
- ap_done during IDLE-load or during SHIFT is legal and buffered in snap.

## Timing
- Reset values: data_out=0, data_valid=0, probe_out=0, overrun=0, full_n=0 on both streams, sig=0, cnt=0, snap_valid=0, FSM=IDLE.
- full_n registered: rises to 1 on the first ap_clk edge after ap_rst deasserts, then stays 1.
- ap_done sampled at edge T → snap_valid=1 after T; shifter loaded at T+1; header visible (data_valid=1) in cycle after T+1 edge; 13 consecutive valid cycles.
- data_valid low for at least one cycle between frames (IDLE load cycle); a buffered snapshot starts exactly one cycle after the previous frame ends.
- probe_out toggles on the edge where data_valid falls after nibble 13.
- ap_rst mid-frame: frame aborted immediately, all state to reset values; no partial frame resumes.

## Test plan
- Reset: hold ap_rst 100 ns → all outputs 0; full_n=1 one cycle after release; no data_valid without ap_done.
- Basic frame: stream0 writes 0x12345678, 0x0000FFFF; stream1 writes 0x00000001; then ap_done → nibbles A,1,2,3,4,A,9,8,5,0,0,0,3; probe_out toggles to 1.
- Same-cycle events: stream0 0xF0F0F0F0 and stream1 0x80000000 together with ap_done → frame A,F,0,F,0,F,0,F,1,0,0,0,2; following run starts at sig=0, cnt=0.
- Back-to-back: second ap_done during frame 1 (empty run) → frame 2 A,0×12 starts exactly one idle cycle after frame 1; overrun stays 0.
- Overrun: three ap_done pulses within one frame → only the first two frames emitted; overrun=1 and remains 1.
- Saturation / mid-reset: 70000 stream0 writes of 0 → count nibbles F,F,F,F; separately assert ap_rst at nibble 6 → data_valid drops in the reset cycle, no further nibbles.

Source files
------------

// File: rtl/dout_nibble_serializer.sv
// dout_nibble_serializer: folds kernel output streams into a per-run signature/count and shifts a nibble frame out on each ap_done
module dout_nibble_serializer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DATA_W-1:0] D_out_0_din,
  input  logic              D_out_0_write,
  output logic              D_out_0_full_n,
  input  logic [DATA_W-1:0] D_out_1_din,
  input  logic              D_out_1_write,
  output logic              D_out_1_full_n,
  input  logic              ap_done,
  output logic [3:0]        data_out,
  output logic              data_valid,
  output logic              probe_out,
  output logic              overrun
);
  localparam int FRAME_W = 4 + DATA_W + CNT_W;
  localparam int NIB = FRAME_W / 4;
  localparam int IDX_W = $clog2(NIB);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t r_state, w_state_next;
  logic               r_full_n, r_snap_valid, r_probe, r_overrun;
  logic [DATA_W-1:0]  r_sig, r_snap_sig, w_sig_next;
  logic [CNT_W-1:0]   r_cnt, r_snap_cnt, w_cnt_next;
  logic [CNT_W:0]     w_cnt_sum;
  logic [FRAME_W-1:0] r_shift;
  logic [IDX_W-1:0]   r_idx;
  logic               w_acc0, w_acc1, w_load, w_last, w_snap_take;
  always_comb begin
    w_acc0 = D_out_0_write & r_full_n;
    w_acc1 = D_out_1_write & r_full_n;
    w_sig_next = r_sig ^ (w_acc0 ? D_out_0_din : '0)
               ^ (w_acc1 ? {D_out_1_din[DATA_W-2:0], D_out_1_din[DATA_W-1]} : '0);
    w_cnt_sum = {1'b0, r_cnt} + (CNT_W+1)'(w_acc0) + (CNT_W+1)'(w_acc1);
    w_cnt_next = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
  end
  always_comb begin
    w_load = (r_state == IDLE) && r_snap_valid;
    w_last = (r_state == SHIFT) && (r_idx == IDX_W'(NIB - 1));
    w_state_next = w_load ? SHIFT : w_last ? IDLE : r_state;
    // the slot being loaded this cycle is free to take a new snapshot
    w_snap_take = ap_done && (!r_snap_valid || w_load);
  end
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_state <= IDLE;
    else r_state <= w_state_next;
  end
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_full_n <= 1'b0;
      r_sig <= '0;
      r_cnt <= '0;
      r_snap_sig <= '0;
      r_snap_cnt <= '0;
      r_snap_valid <= 1'b0;
      r_overrun <= 1'b0;
      r_shift <= '0;
      r_idx <= '0;
      r_probe <= 1'b0;
    end else begin
      r_full_n <= 1'b1;
      r_sig <= ap_done ? '0 : w_sig_next;
      r_cnt <= ap_done ? '0 : w_cnt_next;
      if (w_snap_take) begin
        r_snap_sig <= w_sig_next;
        r_snap_cnt <= w_cnt_next;
      end
      r_snap_valid <= w_snap_take | (r_snap_valid & ~w_load);
      r_overrun <= r_overrun | (ap_done & r_snap_valid & ~w_load);
      if (w_load) begin
        r_shift <= {4'hA, r_snap_sig, r_snap_cnt};
        r_idx <= '0;
      end else if (r_state == SHIFT) begin
        r_shift <= r_shift << 4;
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_last) r_probe <= ~r_probe;
    end
  end
  assign data_valid = (r_state == SHIFT);
  assign data_out = data_valid ? r_shift[FRAME_W-1 -: 4] : 4'h0;
  assign probe_out = r_probe;
  assign overrun = r_overrun;
  assign D_out_0_full_n = r_full_n;
  assign D_out_1_full_n = r_full_n;
endmodule

// File: tb/tb_dout_nibble_serializer.sv
// tb_dout_nibble_serializer: directed frame checks with hand-computed nibble sequences
module tb_dout_nibble_serializer;
  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [31:0] d0 = '0, d1 = '0;
  logic        w0 = 1'b0, w1 = 1'b0, ap_done = 1'b0;
  logic        full0, full1, data_valid, probe_out, overrun;
  logic [3:0]  data_out;
  int          n_assert = 0, n_fail = 0;
  logic        exp_probe = 1'b0;
  dout_nibble_serializer #(.DATA_W(32), .CNT_W(16)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .D_out_0_din(d0), .D_out_0_write(w0), .D_out_0_full_n(full0),
    .D_out_1_din(d1), .D_out_1_write(w1), .D_out_1_full_n(full1),
    .ap_done(ap_done), .data_out(data_out), .data_valid(data_valid),
    .probe_out(probe_out), .overrun(overrun)
  );
  always #5 ap_clk = ~ap_clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic a0, input logic [31:0] v0, input logic a1, input logic [31:0] v1, input logic dn);
    w0 = a0; d0 = v0; w1 = a1; d1 = v1; ap_done = dn;
    @(negedge ap_clk);
    w0 = 1'b0; w1 = 1'b0; ap_done = 1'b0; d0 = '0; d1 = '0;
  endtask
  task automatic expect_frame(input string tag, input logic [51:0] exp, input int n, input logic [12:0] done_mask);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_dv%0d", tag, i), 64'(data_valid), 64'd1);
      check($sformatf("%s_nib%0d", tag, i), 64'(data_out), 64'(exp[51-4*i -: 4]));
      ap_done = done_mask[i];
      @(negedge ap_clk);
    end
    ap_done = 1'b0;
    if (n == 13) begin
      check({tag, "_end_dv"}, 64'(data_valid), 64'd0);
      exp_probe = ~exp_probe;
      check({tag, "_probe"}, 64'(probe_out), 64'(exp_probe));
    end
  endtask
  task automatic quiet(input string tag, input int cycles);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge ap_clk);
      if (data_valid) hits++;
    end
    check(tag, 64'(hits), 64'd0);
  endtask
  initial begin
    #100;
    check("rst_dout", 64'(data_out), 64'd0);
    check("rst_dv", 64'(data_valid), 64'd0);
    check("rst_probe", 64'(probe_out), 64'd0);
    check("rst_ovr", 64'(overrun), 64'd0);
    check("rst_full", 64'({full0, full1}), 64'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    check("full_hold", 64'({full0, full1}), 64'd0);
    @(negedge ap_clk);
    check("full_rise", 64'({full0, full1}), 64'b11);
    quiet("no_spurious", 5);
    // basic frame: sig = 12345678 ^ 0000FFFF ^ rotl(1,1) = 1234A985, cnt 3
    wr(1, 32'h12345678, 0, 0, 0);
    wr(1, 32'h0000FFFF, 1, 32'h00000001, 0);
    wr(0, 0, 0, 0, 1);
    check("basic_pre", 64'(data_valid), 64'd0);
    @(negedge ap_clk);
    expect_frame("basic", 52'hA_1234A985_0003, 13, 13'h0);
    // writes on both streams in the ap_done cycle itself
    wr(1, 32'hF0F0F0F0, 1, 32'h80000000, 1);
    check("same_pre", 64'(data_valid), 64'd0);
    @(negedge ap_clk);
    expect_frame("same", 52'hA_F0F0F0F1_0002, 13, 13'h0);
    // back-to-back: empty run ends during frame 1
    wr(1, 32'h00000001, 0, 0, 0);
    wr(0, 0, 0, 0, 1);
    @(negedge ap_clk);
    expect_frame("b2b1", 52'hA_00000001_0001, 13, 13'h0008);
    @(negedge ap_clk);
    expect_frame("b2b2", 52'hA_00000000_0000, 13, 13'h0);
    check("b2b_ovr", 64'(overrun), 64'd0);
    quiet("b2b_quiet", 4);
    // overrun: two more pulses during the frame, the last is dropped
    wr(0, 0, 1, 32'h40000000, 0);
    wr(0, 0, 0, 0, 1);
    @(negedge ap_clk);
    expect_frame("ovr1", 52'hA_80000000_0001, 13, 13'h0024);
    check("ovr_set", 64'(overrun), 64'd1);
    @(negedge ap_clk);
    expect_frame("ovr2", 52'hA_00000000_0000, 13, 13'h0);
    quiet("ovr_no_third", 20);
    check("ovr_sticky", 64'(overrun), 64'd1);
    // saturation of the word count
    w0 = 1'b1; d0 = '0;
    repeat (70000) @(negedge ap_clk);
    w0 = 1'b0;
    wr(0, 0, 0, 0, 1);
    @(negedge ap_clk);
    expect_frame("sat", 52'hA_00000000_FFFF, 13, 13'h0);
    check("sat_ovr", 64'(overrun), 64'd1);
    // reset in the middle of a frame
    wr(0, 0, 0, 0, 1);
    @(negedge ap_clk);
    expect_frame("mid", 52'hA_00000000_0000, 6, 13'h0);
    ap_rst = 1'b1;
    #1;
    check("mid_dv", 64'(data_valid), 64'd0);
    check("mid_dout", 64'(data_out), 64'd0);
    check("mid_ovr", 64'(overrun), 64'd0);
    check("mid_probe", 64'(probe_out), 64'd0);
    exp_probe = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    quiet("mid_no_resume", 20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
